// File: rtl/spi_picture.sv
// spi_picture: ILI9341 SPI init sequence, full-screen window setup and
// streaming of a generated RGB565 test picture; o_done flags completion.
module spi_picture #(
   parameter int DELAY  = 3_240_000,
   parameter int WIDTH  = 240,
   parameter int HEIGHT = 320
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_start,
   output logic o_mosi,
   output logic o_dc,
   output logic o_cs,
   output logic o_done
);
   localparam logic [15:0] W_M1 = 16'(WIDTH - 1);
   localparam logic [15:0] H_M1 = 16'(HEIGHT - 1);
   localparam logic [31:0] D_M1 = 32'(DELAY - 1);
   localparam logic [4:0]  PIX  = 5'd18;

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

   state_t      state, state_n;
   logic [2:0]  bit_cnt, bit_n;
   logic [4:0]  idx, idx_n;
   logic        hi, hi_n;
   logic [15:0] x, x_n, y, y_n;
   logic [31:0] cnt, cnt_n;
   logic        mosi_n, dc_n, cs_n, done_n;
   logic [7:0]  cur_byte;
   logic        cur_dc;
   logic [4:0]  xy;
   logic [15:0] pix;

   // idx 0..17 walks the command table; idx 18 is the pixel stream
   always_comb begin
      xy = x[4:0] + y[4:0];
      pix = {x[4:0], y[5:0], xy};
      cur_dc = 1'b1;
      cur_byte = 8'h00;
      case (idx)
         5'd0: begin cur_byte = 8'h01; cur_dc = 1'b0; end
         5'd1: begin cur_byte = 8'h11; cur_dc = 1'b0; end
         5'd2: begin cur_byte = 8'h3A; cur_dc = 1'b0; end
         5'd3: cur_byte = 8'h55;
         5'd4: begin cur_byte = 8'h36; cur_dc = 1'b0; end
         5'd5: cur_byte = 8'h48;
         5'd6: begin cur_byte = 8'h29; cur_dc = 1'b0; end
         5'd7: begin cur_byte = 8'h2A; cur_dc = 1'b0; end
         5'd8, 5'd9, 5'd13, 5'd14: cur_byte = 8'h00;
         5'd10: cur_byte = W_M1[15:8];
         5'd11: cur_byte = W_M1[7:0];
         5'd12: begin cur_byte = 8'h2B; cur_dc = 1'b0; end
         5'd15: cur_byte = H_M1[15:8];
         5'd16: cur_byte = H_M1[7:0];
         5'd17: begin cur_byte = 8'h2C; cur_dc = 1'b0; end
         default: cur_byte = hi ? pix[15:8] : pix[7:0];
      endcase
   end

   // outputs are registered next-values so the first bit lands one edge after start
   always_comb begin
      state_n = state;
      bit_n = bit_cnt;
      idx_n = idx;
      hi_n = hi;
      x_n = x;
      y_n = y;
      cnt_n = cnt;
      mosi_n = 1'b0;
      dc_n = 1'b0;
      cs_n = 1'b1;
      done_n = o_done;
      case (state)
         IDLE, DONE: begin
            done_n = (state == DONE);
            if (i_start) begin
               state_n = SEND;
               bit_n = 3'd0;
               idx_n = 5'd0;
               hi_n = 1'b1;
               x_n = 16'd0;
               y_n = 16'd0;
               done_n = 1'b0;
            end
         end
         SEND: begin
            mosi_n = cur_byte[3'd7 - bit_cnt];
            dc_n = cur_dc;
            cs_n = 1'b0;
            bit_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               if (idx != PIX) idx_n = idx + 5'd1;
               if (idx < 5'd2) begin
                  state_n = WAIT;
                  cnt_n = 32'd0;
               end
               if (idx == PIX) begin
                  hi_n = ~hi;
                  if (!hi) begin
                     x_n = (x == W_M1) ? 16'd0 : x + 16'd1;
                     y_n = (x == W_M1) ? y + 16'd1 : y;
                     if (x == W_M1 && y == H_M1) state_n = DONE;
                  end
               end
            end
         end
         WAIT: begin
            cnt_n = cnt + 32'd1;
            if (cnt == D_M1) state_n = SEND;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state <= IDLE;
         bit_cnt <= 3'd0;
         idx <= 5'd0;
         hi <= 1'b1;
         x <= 16'd0;
         y <= 16'd0;
         cnt <= 32'd0;
         o_mosi <= 1'b0;
         o_dc <= 1'b0;
         o_cs <= 1'b1;
         o_done <= 1'b0;
      end else begin
         state <= state_n;
         bit_cnt <= bit_n;
         idx <= idx_n;
         hi <= hi_n;
         x <= x_n;
         y <= y_n;
         cnt <= cnt_n;
         o_mosi <= mosi_n;
         o_dc <= dc_n;
         o_cs <= cs_n;
         o_done <= done_n;
      end
   end
endmodule

// File: tb/tb_spi_picture.sv
// tb_spi_picture: directed bench for spi_picture with DELAY=20 on a 10x10
// picture; decodes the SPI stream and compares it to hand-derived bytes.
`timescale 1ns/1ps
module tb_spi_picture;
   localparam int DELAY  = 20;
   localparam int WIDTH  = 10;
   localparam int HEIGHT = 10;
   localparam int NBYTES = 218;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic mosi, dc, cs, done;
   int checks = 0;
   int errors = 0;
   logic [7:0] init_b [18] = '{8'h01, 8'h11, 8'h3A, 8'h55, 8'h36, 8'h48, 8'h29, 8'h2A, 8'h00,
                               8'h00, 8'h00, 8'h09, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h09, 8'h2C};
   logic [7:0] exp_b [NBYTES];
   logic       exp_d [NBYTES];
   logic [7:0] got_b [$];
   logic       got_d [$];
   int         hi_runs [$];
   int         done_at;
   int         dc_bad;

   spi_picture #(.DELAY(DELAY), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
      .i_clk(clk), .i_rst(rst_n), .i_start(start),
      .o_mosi(mosi), .o_dc(dc), .o_cs(cs), .o_done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // pulse start, then decode bytes on cs-low cycles until o_done; pa/pb are
   // edges after which an extra start pulse is injected (0 = none)
   task automatic capture(input string tag, input int pa, input int pb);
      logic [7:0] sh;
      logic bdc;
      int nb, run;
      sh = 8'h00;
      bdc = 1'b0;
      nb = 0;
      run = 0;
      got_b.delete();
      got_d.delete();
      hi_runs.delete();
      done_at = -1;
      dc_bad = 0;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check($sformatf("%s done clr", tag), done, 0);
      check($sformatf("%s cs edge0", tag), cs, 1);
      for (int e = 1; e <= 4000; e++) begin
         @(posedge clk);
         @(negedge clk);
         start = (e == pa || e == pb);
         if (!cs) begin
            if (run > 0) begin
               hi_runs.push_back(run);
               run = 0;
            end
            if (nb == 0) bdc = dc;
            else if (dc !== bdc) dc_bad++;
            sh = {sh[6:0], mosi};
            nb++;
            if (nb == 8) begin
               got_b.push_back(sh);
               got_d.push_back(bdc);
               nb = 0;
            end
         end else if (done) begin
            done_at = e;
            break;
         end else if (got_b.size() > 0) run++;
      end
      start = 1'b0;
   endtask

   task automatic verify(input string tag);
      check($sformatf("%s nbytes", tag), got_b.size(), NBYTES);
      for (int i = 0; i < NBYTES && i < got_b.size(); i++) begin
         check($sformatf("%s byte%0d", tag, i), got_b[i], exp_b[i]);
         check($sformatf("%s dc%0d", tag, i), got_d[i], exp_d[i]);
      end
      check($sformatf("%s dc steady", tag), dc_bad, 0);
      check($sformatf("%s nwaits", tag), hi_runs.size(), 2);
      for (int i = 0; i < 2 && i < hi_runs.size(); i++)
         check($sformatf("%s wait%0d len", tag, i), hi_runs[i], 20);
      check($sformatf("%s done edge", tag), done_at, 1785);
      if (got_b.size() == NBYTES) begin
         check($sformatf("%s px00", tag), {got_b[18], got_b[19]}, 16'h0000);
         check($sformatf("%s px10", tag), {got_b[20], got_b[21]}, 16'h0801);
         check($sformatf("%s px01", tag), {got_b[38], got_b[39]}, 16'h0021);
         check($sformatf("%s px99", tag), {got_b[216], got_b[217]}, 16'h4932);
      end
   endtask

   initial begin
      logic [15:0] p;
      logic [4:0] s;
      int k, bad;
      for (int i = 0; i < 18; i++) begin
         exp_b[i] = init_b[i];
         exp_d[i] = !(i inside {0, 1, 2, 4, 6, 7, 12, 17});
      end
      for (int yy = 0; yy < HEIGHT; yy++)
         for (int xx = 0; xx < WIDTH; xx++) begin
            s = 5'((xx + yy) % 32);
            p = {xx[4:0], yy[5:0], s};
            k = 18 + 2 * (yy * WIDTH + xx);
            exp_b[k] = p[15:8];
            exp_b[k + 1] = p[7:0];
            exp_d[k] = 1'b1;
            exp_d[k + 1] = 1'b1;
         end

      #12;
      check("rst cs", cs, 1);
      check("rst dc", dc, 0);
      check("rst mosi", mosi, 0);
      check("rst done", done, 0);
      @(negedge clk) rst_n = 1'b1;
      bad = 0;
      repeat (50) @(negedge clk) if ({cs, dc, mosi, done} !== 4'b1000) bad++;
      check("idle after reset", bad, 0);

      capture("run1", 0, 0);
      verify("run1");

      repeat (10) @(negedge clk);
      check("done held", done, 1);
      check("done cs", cs, 1);
      // extra starts land mid-byte of 0x01 and inside the first wait
      capture("run2", 5, 20);
      verify("run2");

      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (1000) @(posedge clk);
      @(negedge clk);
      check("mid stream cs", cs, 0);
      #1 rst_n = 1'b0;
      #1;
      check("async rst cs", cs, 1);
      check("async rst dc", dc, 0);
      check("async rst mosi", mosi, 0);
      check("async rst done", done, 0);
      @(negedge clk) rst_n = 1'b1;
      bad = 0;
      repeat (30) @(negedge clk) if ({cs, dc, mosi, done} !== 4'b1000) bad++;
      check("idle after abort", bad, 0);
      capture("run3", 0, 0);
      verify("run3");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
